// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op bit positions, NOP and FSM encoding.
// Helper flags any alu_ctrl carrying more than one op bit.
package alu_pkg;

    localparam int ALU_W = 10;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_AND   = 2;
    localparam int OP_OR    = 3;
    localparam int OP_XOR   = 4;
    localparam int OP_SLL   = 5;
    localparam int OP_SRL   = 6;
    localparam int OP_SRA   = 7;
    localparam int OP_PASSB = 8;
    localparam int OP_SLT   = 9;

    localparam logic [ALU_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    function automatic logic multi_hot(input logic [ALU_W-1:0] op);
        return (op & (op - ALU_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/shift_iter.sv
// Iterative shifter: one bit per step, 5-bit remaining count loaded with the operand.
// done marks the step that takes the count to zero.
module shift_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic [4:0]  load_cnt,
    input  logic        step,
    input  logic        dir,
    input  logic        arith,
    output logic [31:0] value,
    output logic        done
);

    logic [31:0] val_q, val_d;
    logic [4:0]  cnt_q, cnt_d;

    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (load) begin
            val_d = load_val;
            cnt_d = load_cnt;
        end else if (step && cnt_q != 5'd0) begin
            // dir=1 shifts right; arith fills with the sign bit
            val_d = dir ? {arith & val_q[31], val_q[31:1]} : {val_q[30:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign value = val_q;
    assign done  = (cnt_q == 5'd1);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: accepts one decoded bundle in IDLE, shifts iteratively,
// then presents a one-cycle writeback; dec_en is low while busy (one op per 2+ cycles).
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [ALU_W-1:0] alu_ctrl,
    input  logic [31:0]      imm,
    input  logic             imm_en,
    input  logic [5:0]       sel_a,
    input  logic [4:0]       sel_b,
    input  logic [5:0]       sel_out,
    output logic [5:0]       rf_sel_a,
    output logic [4:0]       rf_sel_b,
    input  logic [31:0]      rf_data_a,
    input  logic [31:0]      rf_data_b,
    output logic             dec_en,
    output logic             wb_en,
    output logic [5:0]       wb_sel,
    output logic [31:0]      wb_data,
    output logic             op_err
);

    state_t           state_q, state_d;
    logic [31:0]      a_q, b_q;
    logic [5:0]       sel_q;
    logic [ALU_W-1:0] ctrl_q;
    logic             op_err_q;

    logic [31:0] op_b, sh_val, alu_res;
    logic        accept, bad_op, is_shift, sh_done, in_wb;

    assign rf_sel_a = sel_a;
    assign rf_sel_b = sel_b;

    assign op_b     = imm_en ? imm : rf_data_b;
    assign bad_op   = multi_hot(alu_ctrl);
    assign is_shift = !bad_op && (alu_ctrl[OP_SLL] || alu_ctrl[OP_SRL] || alu_ctrl[OP_SRA]);
    assign dec_en   = (state_q == ST_IDLE);
    assign accept   = dec_en && dec_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (is_shift && op_b[4:0] != 5'd0) ? ST_SHIFT : ST_WB;
            ST_SHIFT: if (sh_done) state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Illegal multi-hot ops are captured as NOP so they flow through WB silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            ctrl_q   <= NOP;
            op_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= rf_data_a;
                b_q      <= op_b;
                sel_q    <= sel_out;
                ctrl_q   <= bad_op ? NOP : alu_ctrl;
                op_err_q <= op_err_q | bad_op;
            end
        end
    end

    // Shifter is loaded on every accept, so a zero shamt shift yields operand A unchanged
    shift_iter u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (rf_data_a),
        .load_cnt (op_b[4:0]),
        .step     (state_q == ST_SHIFT),
        .dir      (ctrl_q[OP_SRL] | ctrl_q[OP_SRA]),
        .arith    (ctrl_q[OP_SRA]),
        .value    (sh_val),
        .done     (sh_done)
    );

    always_comb begin
        alu_res = '0;
        if      (ctrl_q[OP_ADD])   alu_res = a_q + b_q;
        else if (ctrl_q[OP_SUB])   alu_res = a_q - b_q;
        else if (ctrl_q[OP_AND])   alu_res = a_q & b_q;
        else if (ctrl_q[OP_OR])    alu_res = a_q | b_q;
        else if (ctrl_q[OP_XOR])   alu_res = a_q ^ b_q;
        else if (ctrl_q[OP_SLL] || ctrl_q[OP_SRL] || ctrl_q[OP_SRA]) alu_res = sh_val;
        else if (ctrl_q[OP_PASSB]) alu_res = b_q;
        else if (ctrl_q[OP_SLT])   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
    end

    assign in_wb   = (state_q == ST_WB);
    assign wb_en   = in_wb && (ctrl_q != NOP) && (sel_q != 6'd0);
    assign wb_sel  = in_wb ? sel_q : 6'd0;
    assign wb_data = in_wb ? alu_res : 32'd0;
    assign op_err  = op_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus random bench for alu_issue_ctrl against an arithmetic reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [9:0]  alu_ctrl;
    logic [31:0] imm;
    logic        imm_en;
    logic [5:0]  sel_a;
    logic [4:0]  sel_b;
    logic [5:0]  sel_out;
    logic [5:0]  rf_sel_a;
    logic [4:0]  rf_sel_b;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;
    logic        dec_en;
    logic        wb_en;
    logic [5:0]  wb_sel;
    logic [31:0] wb_data;
    logic        op_err;

    int   errors = 0;
    int   checks = 0;
    logic err_m  = 1'b0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dec_valid (dec_valid),
        .alu_ctrl  (alu_ctrl),
        .imm       (imm),
        .imm_en    (imm_en),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel_out   (sel_out),
        .rf_sel_a  (rf_sel_a),
        .rf_sel_b  (rf_sel_b),
        .rf_data_a (rf_data_a),
        .rf_data_b (rf_data_b),
        .dec_en    (dec_en),
        .wb_en     (wb_en),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data),
        .op_err    (op_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << s;
            6: return a >> s;
            7: return $unsigned($signed(a) >>> s);
            8: return b;
            9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic scramble();
        dec_valid = 1'($urandom);
        alu_ctrl  = 10'($urandom);
        imm       = $urandom;
        imm_en    = 1'($urandom);
        rf_data_a = $urandom;
        rf_data_b = $urandom;
        sel_out   = 6'($urandom);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] rfb, input logic [31:0] im,
                          input logic ie, input logic [9:0] ctrl, input logic [5:0] so);
        logic [31:0] b, exp;
        int          op, lat, s;
        bit          legal, wr;
        @(negedge clk);
        b     = ie ? im : rfb;
        legal = ($countones(ctrl) == 1);
        op    = -1;
        for (int i = 0; i < 10; i++) if (ctrl[i]) op = i;
        exp   = ref_res(op, a, b);
        s     = int'(b[4:0]);
        lat   = (legal && op >= 5 && op <= 7 && s != 0) ? 1 + s : 1;
        wr    = legal && so != 6'd0;
        dec_valid = 1'b1;
        alu_ctrl  = ctrl;
        imm       = im;
        imm_en    = ie;
        rf_data_a = a;
        rf_data_b = rfb;
        sel_out   = so;
        sel_a     = 6'($urandom);
        sel_b     = 5'($urandom);
        #1;
        chk("dec_en_idle", 32'(dec_en), 32'd1);
        chk("rf_sel_a", 32'(rf_sel_a), 32'(sel_a));
        chk("rf_sel_b", 32'(rf_sel_b), 32'(sel_b));
        chk("wb_en_idle", 32'(wb_en), 32'd0);
        chk("op_err_pre", 32'(op_err), 32'(err_m));
        if (ctrl != 10'd0 && !legal) err_m = 1'b1;
        @(posedge clk);
        #1 scramble();
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("dec_en_busy", 32'(dec_en), 32'd0);
            chk("wb_en", 32'(wb_en), 32'((c == lat) && wr));
            chk("op_err", 32'(op_err), 32'(err_m));
            if (c == lat && wr) begin
                chk("wb_sel", 32'(wb_sel), 32'(so));
                chk("wb_data", wb_data, exp);
            end
        end
        dec_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dec_valid = 1'b0; alu_ctrl = '0; imm = '0; imm_en = 1'b0;
        sel_a = '0; sel_b = '0; sel_out = '0; rf_data_a = '0; rf_data_b = '0;
        #12;
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_sel", 32'(wb_sel), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_op_err", 32'(op_err), 32'd0);
        chk("rst_dec_en", 32'(dec_en), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        // ADD with immediate, SUB wrap, SRA by 4
        run_op(32'd5, 32'hDEAD_BEEF, 32'd7, 1'b1, 10'b00_0000_0001, 6'd3);
        run_op(32'd0, 32'd1, 32'h1234, 1'b0, 10'b00_0000_0010, 6'd9);
        run_op(32'h8000_0000, 32'd0, 32'd4, 1'b1, 10'b00_1000_0000, 6'd12);
        // illegal multi-hot, then NOP, then a write to r0
        run_op(32'd1, 32'd2, 32'd3, 1'b0, 10'b00_0000_0011, 6'd4);
        run_op(32'd1, 32'd2, 32'd3, 1'b0, 10'b00_0000_0000, 6'd4);
        run_op(32'd1, 32'd2, 32'd3, 1'b0, 10'b00_0000_0001, 6'd0);
        // shifts by zero and by 31
        run_op(32'hA5A5_0F0F, 32'd0, 32'd32, 1'b1, 10'b00_0010_0000, 6'd1);
        run_op(32'h8000_0001, 32'd0, 32'd31, 1'b1, 10'b00_0100_0000, 6'd2);

        for (int n = 0; n < 40; n++) begin
            logic [9:0] ctrl;
            logic [5:0] so;
            int k;
            k = int'($urandom_range(0, 11));
            if (k < 10)       ctrl = 10'd1 << k;
            else if (k == 10) ctrl = 10'd0;
            else              ctrl = (10'd1 << $urandom_range(0, 4)) | (10'd1 << $urandom_range(5, 9));
            so = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            run_op($urandom, $urandom, $urandom, 1'($urandom), ctrl, so);
        end

        // reset in the middle of a long SLL, then SLT on the first edge after release
        @(negedge clk);
        dec_valid = 1'b1; alu_ctrl = 10'b00_0010_0000; rf_data_a = $urandom;
        imm = 32'd20; imm_en = 1'b1; sel_out = 6'd5;
        @(posedge clk);
        #1 dec_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_shift_dec_en", 32'(dec_en), 32'd0);
        rst_n = 1'b0;
        #1;
        err_m = 1'b0;
        chk("mid_rst_wb_en", 32'(wb_en), 32'd0);
        chk("mid_rst_wb_sel", 32'(wb_sel), 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        chk("mid_rst_op_err", 32'(op_err), 32'd0);
        chk("mid_rst_dec_en", 32'(dec_en), 32'd1);
        #1 rst_n = 1'b1;
        dec_valid = 1'b1; alu_ctrl = 10'b10_0000_0000; rf_data_a = 32'hFFFF_FFFF;
        rf_data_b = 32'd1; imm_en = 1'b0; sel_out = 6'd7;
        @(posedge clk);
        #1 dec_valid = 1'b0;
        @(negedge clk);
        chk("slt_wb_en", 32'(wb_en), 32'd1);
        chk("slt_wb_sel", 32'(wb_sel), 32'd7);
        chk("slt_wb_data", wb_data, 32'd1);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            chk("no_stale_wb", 32'(wb_en), 32'd0);
        end
        chk("final_dec_en", 32'(dec_en), 32'd1);
        chk("final_op_err", 32'(op_err), 32'(err_m));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
